// File: rtl/itoh_tsujii_inv_param.sv
`default_nettype none
// ============================================================================
// Module  : itoh_tsujii_inv_param
// Brief   : GF(2^M) inverter, Itoh-Tsujii chain walked from the bits of M-1.
// Revision: 1.0
// ============================================================================
module itoh_tsujii_inv_param #(
  parameter int         M    = 7,
  parameter logic [M:0] POLY = 8'hBF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [M-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] result,
  output logic         zero_err
);

  localparam int              C_NB    = $clog2(M);
  localparam logic [C_NB-1:0] C_EXP   = C_NB'(M - 1);
  localparam logic [C_NB-1:0] C_MASK0 = C_NB'((1 << C_NB) >> 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SQR   = 3'd1,
    S_MUL   = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_next;
  logic [M-1:0]    r_op, r_beta, r_saved, r_result;
  logic [M-1:0]    w_opb, w_prod;
  logic [C_NB-1:0] r_k, r_sqcnt, r_mask, w_knext, w_mask_nx;
  logic            r_add, r_busy, r_done, r_zero;
  logic            w_accept, w_bit, w_more;

  // Interleaved shift-and-add multiply; reduction folded into each shift.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] acc;
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY[M-1:0] : '0);
      if (y[i]) acc = acc ^ x;
    end
    return acc;
  endfunction

  always_comb begin
    w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_bit     = |(C_EXP & r_mask);
    w_knext   = r_add ? (r_k + C_NB'(1)) : (r_k << 1);
    w_mask_nx = r_mask >> 1;
    w_more    = (w_mask_nx != '0);
    w_opb     = r_beta;
    if (r_state == S_MUL) w_opb = r_add ? r_op : r_saved;
    w_prod    = gf_mul(r_beta, w_opb);
    w_next    = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_next = (C_NB == 1) ? S_FINAL : S_SQR;
        else          w_next = S_IDLE;
      end
      S_SQR:   if (r_sqcnt == C_NB'(1)) w_next = S_MUL;
      S_MUL: begin
        if ((!r_add && w_bit) || w_more) w_next = S_SQR;
        else                             w_next = S_FINAL;
      end
      S_FINAL: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_op     <= '0;
      r_beta   <= '0;
      r_saved  <= '0;
      r_result <= '0;
      r_k      <= '0;
      r_sqcnt  <= '0;
      r_mask   <= '0;
      r_add    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op    <= a;
            r_beta  <= a;
            r_saved <= a;
            r_k     <= C_NB'(1);
            r_sqcnt <= C_NB'(1);
            r_mask  <= C_MASK0;
            r_add   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_SQR: begin
          r_beta <= w_prod;
          if (r_sqcnt != C_NB'(1)) r_sqcnt <= r_sqcnt - C_NB'(1);
        end
        S_MUL: begin
          r_beta <= w_prod;
          r_k    <= w_knext;
          // A set bit after a doubling inserts one extra square-and-multiply by op.
          if (!r_add && w_bit) begin
            r_add   <= 1'b1;
            r_sqcnt <= C_NB'(1);
          end else begin
            r_add   <= 1'b0;
            r_mask  <= w_mask_nx;
            r_sqcnt <= w_knext;
            r_saved <= w_prod;
          end
        end
        S_FINAL: begin
          r_result <= w_prod;
          r_zero   <= (r_op == '0);
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign zero_err = r_zero;

endmodule
`default_nettype wire
